// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: operands captured in parallel on load, then added
// LSB first through one full adder and a carry flop. Final {cout, sum} is
// published on registered outputs only when the N-th bit completes.
module serial_adder #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         load,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    acc_q, acc_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;

  // Full-adder datapath signals for the bit currently at the LSB.
  logic            bit_s;
  logic            bit_c;
  logic [N-1:0]    s_vec;
  logic [N-1:0]    acc_next;
  logic [CW-1:0]   cnt_inc;

  // One full-adder step on the LSBs plus the shifted accumulator value.
  always_comb begin
    bit_s    = a_q[0] ^ b_q[0] ^ carry_q;
    bit_c    = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    // Sum bit enters at the MSB; built as a mask so N=1 needs no empty slice.
    s_vec    = '0;
    s_vec[N-1] = bit_s;
    acc_next = (acc_q >> 1) | s_vec;
    cnt_inc  = cnt_q + CW'(1);
  end

  // Next-state logic: load overrides everything, LOAD/SHIFT process one bit.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    if (load) begin
      a_d     = a;
      b_d     = b;
      acc_d   = '0;
      carry_d = 1'b0;
      cnt_d   = '0;
      state_d = LOAD;
    end else begin
      unique case (state_q)
        LOAD, SHIFT: begin
          a_d     = a_q >> 1;
          b_d     = b_q >> 1;
          acc_d   = acc_next;
          carry_d = bit_c;
          cnt_d   = cnt_inc;
          if (cnt_inc == CW'(N)) begin
            sum_d   = acc_next;
            cout_d  = bit_c;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously by active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder with N=4: table of operand/result vectors
// plus hand-written abort, load-at-completion and reset corner sequences.
module tb_serial_adder;

  logic       clk;
  logic       reset;
  logic [3:0] a;
  logic [3:0] b;
  logic       load;
  logic [3:0] sum;
  logic       cout;

  int unsigned n_checks;
  int unsigned n_pass;

  logic [3:0] exp_sum;
  logic       exp_cout;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       c;
  } vec_t;

  vec_t vecs[8];

  serial_adder #(.N(4)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .load  (load),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] es, input logic ec);
    n_checks++;
    if (sum === es && cout === ec) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got sum=%b cout=%b, expected sum=%b cout=%b",
               name, sum, cout, es, ec);
    end
  endtask

  // Inputs change on negedge; one posedge follows; outputs sampled on negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [3:0] va, input logic [3:0] vb, input int unsigned edges);
    a    = va;
    b    = vb;
    load = 1'b1;
    for (int unsigned i = 0; i < edges; i++) step();
    load = 1'b0;
  endtask

  // Shift 3 edges with operands churning (outputs must hold), then complete.
  task automatic run_op(input string name, input logic [3:0] es, input logic ec);
    for (int unsigned i = 0; i < 3; i++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      step();
      check({name, "_shift_hold"}, exp_sum, exp_cout);
    end
    step();
    exp_sum  = es;
    exp_cout = ec;
    check({name, "_result"}, exp_sum, exp_cout);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp_sum  = '0;
    exp_cout = 1'b0;

    vecs[0] = '{a: 4'b1001, b: 4'b0111, s: 4'b0000, c: 1'b1};
    vecs[1] = '{a: 4'b1110, b: 4'b0111, s: 4'b0101, c: 1'b1};
    vecs[2] = '{a: 4'b0010, b: 4'b1001, s: 4'b1011, c: 1'b0};
    vecs[3] = '{a: 4'b1111, b: 4'b0001, s: 4'b0000, c: 1'b1};
    vecs[4] = '{a: 4'b1111, b: 4'b1111, s: 4'b1110, c: 1'b1};
    vecs[5] = '{a: 4'b0101, b: 4'b1010, s: 4'b1111, c: 1'b0};
    vecs[6] = '{a: 4'b0000, b: 4'b0000, s: 4'b0000, c: 1'b0};
    vecs[7] = '{a: 4'b1000, b: 4'b1000, s: 4'b0000, c: 1'b1};

    // Reset, dominating a simultaneous load.
    reset = 1'b0;
    load  = 1'b1;
    a     = 4'b1111;
    b     = 4'b1111;
    step();
    check("reset_state", 4'b0000, 1'b0);
    load  = 1'b0;
    reset = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      step();
      check("idle_after_reset", 4'b0000, 1'b0);
    end

    // Table: two load edges, four shift edges, then hold.
    for (int unsigned k = 0; k < 8; k++) begin
      do_load(vecs[k].a, vecs[k].b, 2);
      run_op("vec", vecs[k].s, vecs[k].c);
      for (int unsigned i = 0; i < ((k == 0) ? 10 : 2); i++) begin
        step();
        check("done_hold", exp_sum, exp_cout);
      end
    end

    // Abort: reload after two shift edges; only the second op is published.
    do_load(4'b0011, 4'b0001, 1);
    for (int unsigned i = 0; i < 2; i++) begin
      step();
      check("abort_pre", exp_sum, exp_cout);
    end
    do_load(4'b0100, 4'b0100, 1);
    check("abort_reload", exp_sum, exp_cout);
    run_op("abort", 4'b1000, 1'b0);

    // Load on the completion edge wins: no output update.
    do_load(4'b0001, 4'b0001, 1);
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      check("ldcomp_shift", exp_sum, exp_cout);
    end
    do_load(4'b0110, 4'b0011, 1);
    check("ldcomp_no_update", exp_sum, exp_cout);
    run_op("ldcomp", 4'b1001, 1'b0);

    // Reset between edges mid-shift clears outputs without a clock.
    do_load(4'b0111, 4'b0111, 1);
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    exp_sum  = '0;
    exp_cout = 1'b0;
    check("async_reset_mid_shift", exp_sum, exp_cout);
    @(negedge clk);
    reset = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      step();
      check("idle_after_mid_reset", exp_sum, exp_cout);
    end
    do_load(4'b0111, 4'b0111, 1);
    run_op("post_reset", 4'b1110, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial unsigned adder for two N-bit operands. Operands are captured in parallel on a load command, then added one bit per clock, LSB first, through a single full adder and a carry flip-flop. The final N-bit sum and carry-out are presented on registered outputs and held until the next load or reset. It is a low-area arithmetic leaf block for datapaths where latency is less important than gate count.

## Interface
- N, default 4, operand and sum width in bits (N ≥ 1).

- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-low reset (0 clears all state immediately).
- a  input  N  operand A, sampled only while load is high.
- b  input  N  operand B, sampled only while load is high.
- load  input  1  synchronous load command, active-high.
- sum  output  N  registered result a+b mod 2^N.
- cout  output  1  registered carry-out of the N-bit addition.

## Operation
- Internal state:
  - A and B shift registers (N bits each).
  - Sum shift register (N bits).
  - Carry flip-flop.
  - Bit counter, ceil(log2(N+1)) bits.
  - FSM with states IDLE, LOAD, SHIFT, DONE.
  - Output registers for sum and cout.
- Reset (reset=0, asynchronous): all internal registers, sum and cout cleared to 0; FSM goes to IDLE. Reset dominates load.
- Any state, load=1 at a clock edge:
  - A ← a, B ← b.
  - Carry ← 0, counter ← 0, sum shift register ← 0.
  - FSM → LOAD.
  - Repeated load cycles keep re-capturing; the last captured value wins.
- LOAD, load=0 at an edge: FSM → SHIFT, and the first bit is processed on this same edge.
- SHIFT, each edge with load=0:
  - s = A[0] ^ B[0] ^ carry.
  - carry ← majority(A[0], B[0], carry).
  - A and B shift right by one.
  - Sum shift register shifts right with s entering at bit N-1.
  - Counter increments.
- Completion: when the counter reaches N (the N-th processed bit), on that same edge:
  - sum output ← completed sum register (including bit s).
  - cout ← final carry.
  - FSM → DONE.
- DONE and IDLE: sum and cout hold their values; no shifting occurs.
- Output update rule: sum and cout change only on completion or reset; partial results are never visible.
- Arithmetic: unsigned. {cout, sum} = a + b exactly (N+1-bit result).

## Timing
- load is sampled on rising clk edges only.
- Latency: the result is valid immediately after the N-th rising edge that follows the last edge sampling load=1.
  - N=4: 4 edges after load falls.
- Throughput: one addition per N+1 or more cycles (at least one load cycle plus N shift cycles).
- Load asserted during SHIFT: the current operation is aborted with no output update, and the new operands are captured.
- Load asserted in the same cycle as completion: load wins and there is no output update.
- Reset deasserted: the first active edge with load=0 leaves the FSM in IDLE, with outputs at 0.
- Reset asserted mid-SHIFT: everything clears asynchronously; the operation is lost.
- Operands a and b may change freely whenever load=0; they do not affect an operation in progress.

## Test plan
- Reset pulse, then idle with load=0 for 10 cycles -> sum=0000, cout=0 throughout.
- N=4: a=1001, b=0111, load high for 2 edges then low -> after 4 edges sum=0000, cout=1; outputs unchanged during the shift cycles and held 10+ cycles afterward.
- Reset, then a=1110, b=0111, same load sequence -> sum=0101, cout=1.
- Reset, then a=0010, b=1001 -> sum=1011, cout=0; then, without reset, load a=1111, b=0001 -> sum=0000, cout=1.
- Abort: load a=0011, b=0001; after 2 shift edges, reload a=0100, b=0100 -> final sum=1000, cout=0; no intermediate output update occurs.
- Reset mid-SHIFT (assert between edges) -> sum and cout go to 0 immediately without a clock, and stay 0 until the next completed operation.
